branch_resolve: RTL

BRANCH_RESOLVE -- requirements
Module: branch_resolve

---
 rtl/branch_resolve.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/branch_resolve.sv
// branch_resolve
//   Two-stage branch condition resolver. Stage 1 registers the compare
//   request (op, a, b, tag); stage 2 registers the resolved condition, an
//   illegal-op flag and the tag. Results appear 2 cycles after acceptance,
//   with a throughput of one per cycle. stall freezes the whole pipeline;
//   flush drops every in-flight request.
//
//   Optional feature macro: BRANCH_RESOLVE_STATS_EN
//     defined   : br_cnt / tk_cnt count resolved / taken branches and
//                 saturate at all-ones; stats_clr clears them.
//     undefined : br_cnt / tk_cnt are tied to 0 and stats_clr is ignored.
//
// Ports
//   clk, rst           clock, synchronous active-high reset
//   in_valid/in_ready  request handshake (in_ready = !stall)
//   op, a, b, tag_in   compare request (op 110/111 illegal)
//   stall, flush       pipeline freeze / discard in-flight requests
//   out_valid, taken, op_err, tag_out   result
//   stats_clr, br_cnt, tk_cnt           statistics
module branch_resolve #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [TAG_W-1:0] tag_in,
  input  logic             stall,
  input  logic             flush,
  output logic             out_valid,
  output logic             taken,
  output logic             op_err,
  output logic [TAG_W-1:0] tag_out,
  input  logic             stats_clr,
  output logic [CNT_W-1:0] br_cnt,
  output logic [CNT_W-1:0] tk_cnt
);

  localparam logic [2:0] OP_BEQ  = 3'b000;
  localparam logic [2:0] OP_BNE  = 3'b001;
  localparam logic [2:0] OP_BLEZ = 3'b010;
  localparam logic [2:0] OP_BGTZ = 3'b011;
  localparam logic [2:0] OP_BLTZ = 3'b100;
  localparam logic [2:0] OP_BGEZ = 3'b101;

  localparam logic signed [WIDTH-1:0] ZERO_S = '0;

  // Stage 1 registers
  logic             r_vld_p1;
  logic [2:0]       r_op_p1;
  logic [WIDTH-1:0] r_a_p1;
  logic [WIDTH-1:0] r_b_p1;
  logic [TAG_W-1:0] r_tag_p1;

  // Stage 2 registers
  logic             r_vld_p2;
  logic             r_taken_p2;
  logic             r_err_p2;
  logic [TAG_W-1:0] r_tag_p2;

  logic             w_taken;
  logic             w_err;
  logic signed [WIDTH-1:0] w_a_s;

  assign in_ready = !stall;
  assign w_a_s    = r_a_p1;

  // ---- stage 1: capture request ----
  // Data flops carry no reset; only the valid bit is cleared.
  always_ff @(posedge clk) begin
    if (!stall && in_valid) begin
      r_op_p1  <= op;
      r_a_p1   <= a;
      r_b_p1   <= b;
      r_tag_p1 <= tag_in;
    end
  end

  // Condition evaluation on the stage-1 operands.
  always_comb begin
    w_taken = 1'b0;
    w_err   = 1'b0;
    case (r_op_p1)
      OP_BEQ:  w_taken = (r_a_p1 == r_b_p1);
      OP_BNE:  w_taken = (r_a_p1 != r_b_p1);
      OP_BLEZ: w_taken = (w_a_s <= ZERO_S);
      OP_BGTZ: w_taken = (w_a_s >  ZERO_S);
      OP_BLTZ: w_taken = (w_a_s <  ZERO_S);
      OP_BGEZ: w_taken = (w_a_s >= ZERO_S);
      default: w_err   = 1'b1;
    endcase
  end

  // ---- stage 2: register result ----
  // taken/op_err are gated with valid so they read 0 whenever out_valid=0;
  // tag_out only moves when a real result arrives, so it holds otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld_p1   <= 1'b0;
      r_vld_p2   <= 1'b0;
      r_taken_p2 <= 1'b0;
      r_err_p2   <= 1'b0;
      r_tag_p2   <= '0;
    end else if (flush) begin
      r_vld_p1   <= 1'b0;
      r_vld_p2   <= 1'b0;
      r_taken_p2 <= 1'b0;
      r_err_p2   <= 1'b0;
    end else if (!stall) begin
      r_vld_p1   <= in_valid;
      r_vld_p2   <= r_vld_p1;
      r_taken_p2 <= r_vld_p1 & w_taken;
      r_err_p2   <= r_vld_p1 & w_err;
      if (r_vld_p1) begin
        r_tag_p2 <= r_tag_p1;
      end
    end
  end

  assign out_valid = r_vld_p2;
  assign taken     = r_taken_p2;
  assign op_err    = r_err_p2;
  assign tag_out   = r_tag_p2;

`ifdef BRANCH_RESOLVE_STATS_EN
  logic [CNT_W-1:0] r_br_cnt;
  logic [CNT_W-1:0] r_tk_cnt;
  logic             w_br_inc;
  logic             w_tk_inc;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == {CNT_W{1'b1}}) begin
      return v;
    end
    return v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  // A result is counted once, on the cycle it leaves the output stage.
  assign w_br_inc = r_vld_p2 && !r_err_p2 && !stall;
  assign w_tk_inc = w_br_inc && r_taken_p2;

  always_ff @(posedge clk) begin
    if (rst || stats_clr) begin
      r_br_cnt <= '0;
      r_tk_cnt <= '0;
    end else begin
      if (w_br_inc) begin
        r_br_cnt <= sat_inc(r_br_cnt);
      end
      if (w_tk_inc) begin
        r_tk_cnt <= sat_inc(r_tk_cnt);
      end
    end
  end

  assign br_cnt = r_br_cnt;
  assign tk_cnt = r_tk_cnt;
`else
  logic w_unused_stats_clr;
  assign w_unused_stats_clr = stats_clr;
  assign br_cnt = '0;
  assign tk_cnt = '0;
`endif

endmodule
